// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Fractional baud-rate tick generator for the UART TX/RX FSMs.
// A cycle counter runs from 0 up to a terminal limit of active_int + carry.
// When it reaches the limit, one end-of-period event occurs. Each event adds
// the fractional divisor into a phase accumulator, and the accumulator's
// carry out stretches the following period by one cycle. Over time the
// average tick spacing is therefore div_int + 1 + div_frac / 2^FRAC_BITS.
// Each event also advances an oversample phase counter, which produces
// mid-bit and bit-boundary ticks.
//
// Divisor updates go through a shadow register. A load is captured
// immediately, but it only reaches the active divisor at a safe point:
// - at an end-of-period event, or
// - while the generator is paused (enable low), or
// - on a synchronous clear.
// This keeps the period that is already in progress intact.
//
// There is no FSM in this block. The only sequencing state is cnt, acc,
// carry and phase. phase is exported directly.
module baud_tick_gen #(
  parameter int              BITS        = 10,
  parameter int              FRAC_BITS   = 4,
  parameter int              OVERSAMPLE  = 16,
  parameter logic [BITS-1:0] DEFAULT_INT = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          load,
  input  logic [BITS-1:0]               div_int,
  input  logic [FRAC_BITS-1:0]          div_frac,
  output logic                          sample_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase
);

  // OVERSAMPLE must be a power of two (>= 2), so the phase counter wraps
  // naturally at its own width.
  localparam int              PH_W      = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] MID_PHASE = PH_W'(OVERSAMPLE / 2);
  localparam logic [BITS:0]   CNT_ONE   = (BITS+1)'(1);

  // Counter is one bit wider than the divisor. The limit can reach
  // 2^BITS when active_int is all ones and the carry is set.
  logic [BITS:0]          cnt;
  logic [FRAC_BITS-1:0]   acc;
  logic                   carry;

  // Active divisor (in use) and shadow divisor (last load not yet applied).
  logic [BITS-1:0]        act_int;
  logic [FRAC_BITS-1:0]   act_frac;
  logic [BITS-1:0]        shadow_int;
  logic [FRAC_BITS-1:0]   shadow_frac;
  logic                   pend;

  logic [BITS:0]          limit;
  logic                   period_end;
  logic [FRAC_BITS:0]     frac_sum;
  logic [PH_W-1:0]        phase_next;
  logic                   pend_eff;
  logic [BITS-1:0]        next_int;
  logic [FRAC_BITS-1:0]   next_frac;
  logic                   apply_div;

  // Period bookkeeping and divisor hand-over decisions.
  always_comb begin
    limit      = {1'b0, act_int} + {{BITS{1'b0}}, carry};
    // clear wins over enable and suppresses the event entirely.
    period_end = enable & ~clear & (cnt == limit);
    frac_sum   = {1'b0, acc} + {1'b0, act_frac};
    phase_next = phase + PH_W'(1);
    // A load arriving on the same edge as a hand-over point is forwarded.
    // This way "load with clear" and "load while paused" take effect at once.
    pend_eff   = pend | load;
    next_int   = load ? div_int  : shadow_int;
    next_frac  = load ? div_frac : shadow_frac;
    apply_div  = pend_eff & (clear | ~enable | period_end);
  end

  // Cycle counter: restart on clear, hold while paused, otherwise count to
  // the limit and wrap to zero.
  // If a paused reload shrinks the divisor below an in-flight count, the
  // counter runs round its full width before it matches again. A clear
  // restarts it cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (period_end) cnt <= '0;
      else            cnt <= cnt + CNT_ONE;
    end
  end

  // Fractional accumulator and oversample phase, both advanced once per
  // period end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      carry <= 1'b0;
      phase <= '0;
    end else if (clear) begin
      acc   <= '0;
      carry <= 1'b0;
      phase <= '0;
    end else if (period_end) begin
      {carry, acc} <= frac_sum;
      phase        <= phase_next;
    end
  end

  // Shadow capture on load. The active divisor is replaced only at a safe
  // hand-over point. The last load before that point wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_int  <= DEFAULT_INT;
      shadow_frac <= '0;
      act_int     <= DEFAULT_INT;
      act_frac    <= '0;
      pend        <= 1'b0;
    end else begin
      if (load) begin
        shadow_int  <= div_int;
        shadow_frac <= div_frac;
      end
      if (apply_div) begin
        act_int  <= next_int;
        act_frac <= next_frac;
        pend     <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  // Registered tick outputs. mid and bit ticks are qualified by the phase
  // value that this event moves into.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_tick <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      sample_tick <= period_end;
      mid_tick    <= period_end & (phase_next == MID_PHASE);
      bit_tick    <= period_end & (phase_next == '0);
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen
// Directed scenarios with literal expected tick spacings, followed by a
// randomized run. The randomized run is compared cycle by cycle against a
// behavioural model. The model counts elapsed cycles per period and uses
// integer arithmetic for the fractional accumulator.
module tb_baud_tick_gen;

  localparam int BITS       = 10;
  localparam int FRAC_BITS  = 4;
  localparam int OVERSAMPLE = 16;
  localparam int PH_W       = 4;
  localparam int FRAC_MOD   = 1 << FRAC_BITS;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 clear;
  logic                 load;
  logic [BITS-1:0]      div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 sample_tick;
  logic                 mid_tick;
  logic                 bit_tick;
  logic [PH_W-1:0]      phase;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .BITS        (BITS),
    .FRAC_BITS   (FRAC_BITS),
    .OVERSAMPLE  (OVERSAMPLE),
    .DEFAULT_INT (10'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .load        (load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick),
    .phase       (phase)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  logic [15:0] exp_q[$];

  // ---------------- behavioural reference model ----------------
  int m_elapsed, m_acc, m_carry, m_phase;
  int m_act_int, m_act_frac, m_sh_int, m_sh_frac;
  bit m_pend;
  bit exp_sample, exp_mid, exp_bit;

  task automatic model_reset();
    m_elapsed = 0; m_acc = 0; m_carry = 0; m_phase = 0;
    m_act_int = 0; m_act_frac = 0; m_sh_int = 0; m_sh_frac = 0;
    m_pend = 0;
    exp_sample = 0; exp_mid = 0; exp_bit = 0;
  endtask

  // One clock edge of the model: a period lasts act_int + carry + 1 enabled cycles.
  task automatic model_edge();
    bit tick;
    tick = 0;
    exp_sample = 0; exp_mid = 0; exp_bit = 0;
    if (load) begin
      m_sh_int = int'(div_int); m_sh_frac = int'(div_frac); m_pend = 1;
    end
    if (clear) begin
      m_elapsed = 0; m_acc = 0; m_carry = 0; m_phase = 0;
    end else if (enable) begin
      m_elapsed++;
      if (m_elapsed == m_act_int + m_carry + 1) begin
        tick = 1;
        m_elapsed = 0;
        m_acc = m_acc + m_act_frac;
        m_carry = (m_acc >= FRAC_MOD) ? 1 : 0;
        m_acc = m_acc % FRAC_MOD;
        m_phase = (m_phase + 1) % OVERSAMPLE;
        exp_sample = 1;
        exp_bit = (m_phase == 0);
        exp_mid = (m_phase == OVERSAMPLE / 2);
      end
    end
    if (m_pend && (clear || !enable || tick)) begin
      m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pend = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are stable from the previous negedge, outputs
  // are sampled at the following negedge.
  task automatic cyc();
    @(posedge clk);
    if (reset === 1'b1) model_edge();
    else                model_reset();
    cyc_n++;
    @(negedge clk);
  endtask

  // Clear with a simultaneous load of the new divisor, then run.
  task automatic setup(input int di, input int df);
    enable = 1'b0; clear = 1'b1; load = 1'b1;
    div_int = BITS'(di); div_frac = FRAC_BITS'(df);
    cyc();
    clear = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  task automatic wait_tick(input int max_cyc, output int waited, output bit seen);
    waited = 0; seen = 0;
    while (!seen && waited < max_cyc) begin
      cyc();
      waited++;
      if (sample_tick === 1'b1) seen = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) cyc();
    n_vec++;
    if ({sample_tick, mid_tick, bit_tick, phase} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_state: got s=%b m=%b b=%b ph=%0d, expected all 0", sample_tick, mid_tick, bit_tick, phase);
    end
    reset = 1'b1;
    repeat (3) cyc();
    n_vec++;
    if ({sample_tick, mid_tick, bit_tick, phase} !== 7'd0) begin
      n_err++;
      $display("FAIL disabled_idle: got s=%b m=%b b=%b ph=%0d, expected all 0", sample_tick, mid_tick, bit_tick, phase);
    end
    enable = 1'b1;
    cyc();
    n_vec++;
    if ({sample_tick, mid_tick, bit_tick, phase} !== {3'b100, 4'd1}) begin
      n_err++;
      $display("FAIL default_first_tick: got s=%b m=%b b=%b ph=%0d, expected s=1 m=0 b=0 ph=1", sample_tick, mid_tick, bit_tick, phase);
    end
    enable = 1'b0;
  endtask

  task automatic test_int3();
    int w; bit seen; int last_bit; int exp_ph;
    setup(3, 0);
    last_bit = -1;
    wait_tick(20, w, seen);
    n_vec++;
    if (!seen || w != 4) begin
      n_err++; $display("FAIL int3_first: waited %0d seen=%0b, expected 4", w, seen);
    end
    for (int k = 2; k <= 40; k++) begin
      wait_tick(20, w, seen);
      exp_ph = k % OVERSAMPLE;
      n_vec++;
      if (!seen || w != 4) begin
        n_err++; $display("FAIL int3_spacing: tick %0d waited %0d seen=%0b, expected 4", k, w, seen);
      end
      n_vec++;
      if ({mid_tick, bit_tick, phase} !== {exp_ph == OVERSAMPLE / 2, exp_ph == 0, 4'(exp_ph)}) begin
        n_err++;
        $display("FAIL int3_phase: tick %0d got m=%b b=%b ph=%0d, expected ph=%0d", k, mid_tick, bit_tick, phase, exp_ph);
      end
      if (bit_tick === 1'b1) begin
        if (last_bit >= 0) begin
          n_vec++;
          if (cyc_n - last_bit != 64) begin
            n_err++; $display("FAIL int3_bit_period: got %0d cycles, expected 64", cyc_n - last_bit);
          end
        end
        last_bit = cyc_n;
      end
      if (mid_tick === 1'b1 && last_bit >= 0) begin
        n_vec++;
        if (cyc_n - last_bit != 32) begin
          n_err++; $display("FAIL int3_mid_offset: got %0d cycles after bit_tick, expected 32", cyc_n - last_bit);
        end
      end
    end
  endtask

  task automatic test_frac();
    int w; bit seen; int total; int k; logic [15:0] e;
    setup(3, 8);
    exp_q.delete();
    exp_q.push_back(16'd4);
    for (int p = 2; p <= 33; p++) exp_q.push_back((p % 2 == 1) ? 16'd5 : 16'd4);
    total = 0; k = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(20, w, seen);
      n_vec++;
      if (!seen || w != int'(e)) begin
        n_err++; $display("FAIL frac_spacing: period %0d waited %0d seen=%0b, expected %0d", k, w, seen, e);
      end
      if (k > 1) total += w;
      k++;
    end
    n_vec++;
    if (total != 144) begin
      n_err++; $display("FAIL frac_total: got %0d cycles over 32 spacings, expected 144", total);
    end
  endtask

  task automatic test_reload();
    int w; bit seen; int t_last;
    setup(3, 0);
    wait_tick(20, w, seen);
    t_last = cyc_n;
    cyc();
    load = 1'b1; div_int = 10'd7; div_frac = 4'd0;
    cyc();
    load = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'd4); exp_q.push_back(16'd8); exp_q.push_back(16'd8); exp_q.push_back(16'd8);
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      wait_tick(20, w, seen);
      n_vec++;
      if (!seen || cyc_n - t_last != int'(e)) begin
        n_err++; $display("FAIL reload_spacing: got %0d seen=%0b, expected %0d", cyc_n - t_last, seen, e);
      end
      t_last = cyc_n;
    end
  endtask

  task automatic test_back_to_back();
    int w; bit seen; int t_last;
    setup(3, 0);
    wait_tick(20, w, seen);
    t_last = cyc_n;
    cyc();
    load = 1'b1; div_int = 10'd9;
    cyc();
    div_int = 10'd2;
    cyc();
    load = 1'b0;
    wait_tick(20, w, seen);
    n_vec++;
    if (!seen || cyc_n - t_last != 4) begin
      n_err++; $display("FAIL b2b_current: got %0d seen=%0b, expected 4", cyc_n - t_last, seen);
    end
    t_last = cyc_n;
    wait_tick(20, w, seen);
    n_vec++;
    if (!seen || cyc_n - t_last != 3) begin
      n_err++; $display("FAIL b2b_last_wins: got %0d seen=%0b, expected 3", cyc_n - t_last, seen);
    end
  endtask

  task automatic test_enable_gap();
    int w; bit seen; int t0;
    setup(5, 0);
    wait_tick(20, w, seen);
    t0 = cyc_n;
    repeat (2) cyc();
    enable = 1'b0;
    repeat (5) cyc();
    n_vec++;
    if ({sample_tick, phase} !== {1'b0, 4'd1}) begin
      n_err++; $display("FAIL gap_freeze: got s=%b ph=%0d, expected s=0 ph=1", sample_tick, phase);
    end
    enable = 1'b1;
    wait_tick(30, w, seen);
    n_vec++;
    if (!seen || cyc_n - t0 != 11) begin
      n_err++; $display("FAIL gap_delay: got %0d seen=%0b, expected 11", cyc_n - t0, seen);
    end
    n_vec++;
    if (phase !== 4'd2) begin
      n_err++; $display("FAIL gap_phase: got %0d, expected 2", phase);
    end
  endtask

  task automatic test_clear_load();
    int n;
    setup(3, 0);
    n = 0;
    while (phase !== 4'd9 && n < 60) begin
      cyc(); n++;
    end
    n_vec++;
    if (phase !== 4'd9) begin
      n_err++; $display("FAIL clr_reach_phase9: got %0d after %0d cycles, expected 9", phase, n);
    end
    clear = 1'b1; load = 1'b1; div_int = 10'd1; div_frac = 4'd0;
    cyc();
    clear = 1'b0; load = 1'b0;
    n_vec++;
    if ({sample_tick, phase} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL clr_cycle: got s=%b ph=%0d, expected s=0 ph=0", sample_tick, phase);
    end
    cyc();
    n_vec++;
    if (sample_tick !== 1'b0) begin
      n_err++; $display("FAIL clr_no_early_tick: got s=%b, expected 0", sample_tick);
    end
    cyc();
    n_vec++;
    if ({sample_tick, phase} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL clr_first_tick: got s=%b ph=%0d, expected s=1 ph=1", sample_tick, phase);
    end
    repeat (2) cyc();
    n_vec++;
    if ({sample_tick, phase} !== {1'b1, 4'd2}) begin
      n_err++; $display("FAIL clr_second_tick: got s=%b ph=%0d, expected s=1 ph=2", sample_tick, phase);
    end
  endtask

  task automatic test_int0_reset();
    int ep;
    setup(0, 0);
    for (int i = 1; i <= 48; i++) begin
      cyc();
      ep = i % OVERSAMPLE;
      n_vec++;
      if ({sample_tick, mid_tick, bit_tick, phase} !== {1'b1, ep == OVERSAMPLE / 2, ep == 0, 4'(ep)}) begin
        n_err++;
        $display("FAIL int0_stream: cycle %0d got s=%b m=%b b=%b ph=%0d, expected ph=%0d", i, sample_tick, mid_tick, bit_tick, phase, ep);
      end
    end
    repeat (5) cyc();
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({sample_tick, mid_tick, bit_tick, phase} !== 7'd0) begin
      n_err++; $display("FAIL async_reset: got s=%b m=%b b=%b ph=%0d, expected all 0", sample_tick, mid_tick, bit_tick, phase);
    end
    @(negedge clk);
    cyc();
    reset = 1'b1;
    cyc();
    n_vec++;
    if ({sample_tick, mid_tick, bit_tick, phase} !== {3'b100, 4'd1}) begin
      n_err++; $display("FAIL post_reset_tick: got s=%b m=%b b=%b ph=%0d, expected s=1 ph=1", sample_tick, mid_tick, bit_tick, phase);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 19) == 0);
      div_int  = BITS'($urandom_range(0, 6));
      div_frac = FRAC_BITS'($urandom_range(0, FRAC_MOD - 1));
      cyc();
      n_vec++;
      if ({sample_tick, mid_tick, bit_tick, phase} !== {exp_sample, exp_mid, exp_bit, 4'(m_phase)}) begin
        n_err++;
        $display("FAIL random_step: cycle %0d got s=%b m=%b b=%b ph=%0d, expected s=%b m=%b b=%b ph=%0d",
                 i, sample_tick, mid_tick, bit_tick, phase, exp_sample, exp_mid, exp_bit, m_phase);
      end
    end
    clear = 1'b0; load = 1'b0;
  endtask

  // ---------------- sequencing and final report ----------------
  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
    div_int = '0; div_frac = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_int3();
    test_frac();
    test_reload();
    test_back_to_back();
    test_enable_gap();
    test_clear_load();
    test_int0_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
